// File: rtl/input_debouncer.sv
// Board switch/button conditioning: 2-flop sync, per-bit stability debounce, press pulses.
// Define INPUT_DEBOUNCE_EN to compile in the stability counters; otherwise d follows s2 directly.
module input_debouncer #(
    parameter int unsigned SW_WIDTH        = 18,
    parameter int unsigned BTN_WIDTH       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [SW_WIDTH-1:0]  i_sw_raw,
    input  logic [BTN_WIDTH-1:0] i_btn_raw,
    output logic [31:0]          o_io_sw,
    output logic [31:0]          o_io_btn,
    output logic [BTN_WIDTH-1:0] o_btn_press
);

    localparam int unsigned IN_W  = SW_WIDTH + BTN_WIDTH;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > (32'd1 << 24))) begin : g_bad_cfg
        $error("input_debouncer: DEBOUNCE_CYCLES must be within 2 .. 2**24");
    end

    logic [BTN_WIDTH-1:0] btn_norm;
    logic [IN_W-1:0]      s1_d, s1_q;
    logic [IN_W-1:0]      s2_d, s2_q;
    logic [IN_W-1:0]      deb_d, deb_q;
    logic [BTN_WIDTH-1:0] deb_btn;
    logic [BTN_WIDTH-1:0] btn_prev_d, btn_prev_q;
    logic [BTN_WIDTH-1:0] press_d, press_q;

    // Buttons are normalised to 1 = pressed before entering the synchroniser.
    always_comb begin
        btn_norm = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;
        s1_d     = {btn_norm, i_sw_raw};
        s2_d     = s1_q;
    end

`ifdef INPUT_DEBOUNCE_EN
    logic [IN_W-1:0][CNT_W-1:0] cnt_d, cnt_q;

    // Any cycle with s2 == d restarts the window, so only a full stable run is accepted.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        deb_d = s2_q;
    end
`endif

    // Press pulse is the registered rising edge of the debounced button state.
    always_comb begin
        deb_btn    = deb_q[IN_W-1 -: BTN_WIDTH];
        btn_prev_d = deb_btn;
        press_d    = deb_btn & ~btn_prev_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            btn_prev_q <= '0;
            press_q    <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            btn_prev_q <= btn_prev_d;
            press_q    <= press_d;
        end
    end

    assign o_io_sw     = 32'(deb_q[SW_WIDTH-1:0]);
    assign o_io_btn    = 32'(deb_btn);
    assign o_btn_press = press_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES = 8 (both INPUT_DEBOUNCE_EN builds).
module tb_input_debouncer;

    localparam int unsigned SW_W  = 18;
    localparam int unsigned BTN_W = 4;
    localparam int unsigned DC    = 8;
`ifdef INPUT_DEBOUNCE_EN
    localparam int LAT = DC + 2;
`else
    localparam int LAT = 3;
`endif

    logic             clk;
    logic             rst_n;
    logic [SW_W-1:0]  sw_raw;
    logic [BTN_W-1:0] btn_raw;
    logic [31:0]      io_sw;
    logic [31:0]      io_btn;
    logic [BTN_W-1:0] btn_press;

    int n_cmp;
    int n_err;

    input_debouncer #(
        .SW_WIDTH       (SW_W),
        .BTN_WIDTH      (BTN_W),
        .DEBOUNCE_CYCLES(DC),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sw_raw   (sw_raw),
        .i_btn_raw  (btn_raw),
        .o_io_sw    (io_sw),
        .o_io_btn   (io_btn),
        .o_btn_press(btn_press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [SW_W-1:0]  sw;
        logic [BTN_W-1:0] btn;
        int               wait_cyc;
        logic [31:0]      exp_sw;
        logic [31:0]      exp_btn;
        logic [BTN_W-1:0] exp_press;
    } vec_t;

    vec_t vecs [12];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [31:0] e_sw,
                           input logic [31:0] e_btn, input logic [BTN_W-1:0] e_press);
        chk({name, "/sw"}, io_sw, e_sw);
        chk({name, "/btn"}, io_btn, e_btn);
        chk({name, "/press"}, 32'(btn_press), 32'(e_press));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // btn raw is active-low: 4'hF = none pressed, 4'hB = button 2 pressed
        vecs[0]  = '{18'h00001, 4'hF, LAT - 1, 32'h0,     32'h0, 4'h0};
        vecs[1]  = '{18'h00001, 4'hF, 1,       32'h1,     32'h0, 4'h0};
        vecs[2]  = '{18'h00001, 4'hB, LAT - 1, 32'h1,     32'h0, 4'h0};
        vecs[3]  = '{18'h00001, 4'hB, 1,       32'h1,     32'h4, 4'h0};
        vecs[4]  = '{18'h00001, 4'hB, 1,       32'h1,     32'h4, 4'h4};
        vecs[5]  = '{18'h00001, 4'hB, 1,       32'h1,     32'h4, 4'h0};
        vecs[6]  = '{18'h00001, 4'hF, LAT - 1, 32'h1,     32'h4, 4'h0};
        vecs[7]  = '{18'h00001, 4'hF, 1,       32'h1,     32'h0, 4'h0};
        vecs[8]  = '{18'h00001, 4'hF, 1,       32'h1,     32'h0, 4'h0};
        vecs[9]  = '{18'h20005, 4'h6, LAT,     32'h20005, 32'h9, 4'h0};
        vecs[10] = '{18'h20005, 4'h6, 1,       32'h20005, 32'h9, 4'h9};
        vecs[11] = '{18'h00000, 4'hF, LAT,     32'h0,     32'h0, 4'h0};

        // Reset held with every input active
        rst_n   = 1'b0;
        sw_raw  = 18'h3FFFF;
        btn_raw = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk_all($sformatf("rst_hold%0d", i), 32'h0, 32'h0, 4'h0);
        end
        rst_n = 1'b1;
        tick(LAT - 1);
        chk_all("rst_rel_early", 32'h0, 32'h0, 4'h0);
        tick(1);
        chk_all("rst_rel_accept", 32'h3FFFF, 32'hF, 4'h0);
        tick(1);
        chk_all("rst_rel_press", 32'h3FFFF, 32'hF, 4'hF);
        tick(1);
        chk_all("rst_rel_press_end", 32'h3FFFF, 32'hF, 4'h0);

        // Back to idle; the release must not pulse
        sw_raw  = '0;
        btn_raw = 4'hF;
        tick(LAT);
        chk_all("idle", 32'h0, 32'h0, 4'h0);

        for (int i = 0; i < 12; i++) begin
            sw_raw  = vecs[i].sw;
            btn_raw = vecs[i].btn;
            tick(vecs[i].wait_cyc);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_sw, vecs[i].exp_btn, vecs[i].exp_press);
        end

`ifdef INPUT_DEBOUNCE_EN
        // Bounce on sw[3]: 7 high, 1 low, then held high
        sw_raw = 18'h00008;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk($sformatf("bounce_a%0d", i), 32'(io_sw[3]), 32'h0);
        end
        sw_raw = 18'h00000;
        tick(1);
        chk("bounce_low", 32'(io_sw[3]), 32'h0);
        sw_raw = 18'h00008;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            chk($sformatf("bounce_b%0d", i), 32'(io_sw[3]), 32'h0);
        end
        tick(1);
        chk("bounce_accept", io_sw, 32'h8);
        sw_raw = '0;
        tick(LAT + 1);
        chk("bounce_clear", io_sw, 32'h0);
`endif

        // One-cycle pulse on sw[1]: filtered when debouncing, passed after 3 edges otherwise
        sw_raw = 18'h00002;
        tick(1);
        sw_raw = 18'h00000;
        chk("pulse_t1", io_sw, 32'h0);
        for (int t = 2; t <= 12; t++) begin
            tick(1);
`ifdef INPUT_DEBOUNCE_EN
            chk($sformatf("pulse_t%0d", t), io_sw, 32'h0);
`else
            chk($sformatf("pulse_t%0d", t), io_sw, (t == 3) ? 32'h2 : 32'h0);
`endif
        end

        // Reset in the middle of a count restarts the full window
        sw_raw = 18'h00010;
        tick(5);
        rst_n = 1'b0;
        tick(2);
        chk_all("midrst_hold", 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        tick(LAT - 1);
        chk_all("midrst_early", 32'h0, 32'h0, 4'h0);
        tick(1);
        chk_all("midrst_accept", 32'h10, 32'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
